spi_controller: RTL and testbench

SPI mode-0 controller (initiator) that turns a one-beat command handshake into a 16-bit frame: R/W bit, 7-bit address, 8-bit data. It drives the `sCLK`/`nCS`/`COPI` pins consumed by `spi_peripheral`. It is used as on-chip stimulus and loopback master, and as the bench-side driver for register programming of the PWM/output-enable block. The frame is MSB first, and sCLK is generated by dividing `clk` so that the peripheral's synchronisers see clean edges.

---
 rtl/spi_controller.sv | 139 +++++++++++++
 tb/tb_spi_controller.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: one command beat becomes a 16-bit {rw, addr, wdata} frame, MSB first.
// Define SPI_CTRL_CIPO_EN to build the CIPO input and the rsp_rdata read-back register.
module spi_controller #(
  parameter int HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       sCLK,
  output logic       nCS,
  output logic       COPI,
  output logic       busy,
`ifdef SPI_CTRL_CIPO_EN
  input  logic       CIPO,
  output logic [7:0] rsp_rdata,
`endif
  output logic       done
);

  localparam int DIV_W = $clog2(2 * HALF_PERIOD);
  localparam logic [DIV_W-1:0] HALF_RELOAD = DIV_W'(HALF_PERIOD - 1);
  localparam logic [DIV_W-1:0] GAP_RELOAD  = DIV_W'(2 * HALF_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_cnt;
  logic [14:0]      shift_reg;
  logic             div_zero;

  assign div_zero = (div_cnt == '0);

  // bit 15 goes straight to COPI at accept, so only the remaining 15 bits are held for shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      sCLK      <= 1'b0;
      nCS       <= 1'b1;
      COPI      <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            shift_reg <= {cmd_addr, cmd_wdata};
            COPI      <= cmd_rw;
            nCS       <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            bit_cnt   <= 4'd15;
            div_cnt   <= HALF_RELOAD;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (div_zero) begin
            sCLK    <= 1'b1;
            div_cnt <= HALF_RELOAD;
            state   <= SHIFT_HI;
          end else begin
            div_cnt <= div_cnt - DIV_ONE;
          end
        end
        SHIFT_HI: begin
          if (div_zero) begin
            sCLK    <= 1'b0;
            div_cnt <= HALF_RELOAD;
            state   <= SHIFT_LO;
            // after the last bit the low phase is a hold phase, COPI keeps bit 0
            if (bit_cnt != 4'd0) begin
              COPI      <= shift_reg[14];
              shift_reg <= {shift_reg[13:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt - DIV_ONE;
          end
        end
        SHIFT_LO: begin
          if (div_zero) begin
            if (bit_cnt == 4'd0) begin
              nCS     <= 1'b1;
              COPI    <= 1'b0;
              done    <= 1'b1;
              div_cnt <= GAP_RELOAD;
              state   <= GAP;
            end else begin
              sCLK    <= 1'b1;
              bit_cnt <= bit_cnt - 4'd1;
              div_cnt <= HALF_RELOAD;
              state   <= SHIFT_HI;
            end
          end else begin
            div_cnt <= div_cnt - DIV_ONE;
          end
        end
        GAP: begin
          if (div_zero) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            div_cnt <= div_cnt - DIV_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_CTRL_CIPO_EN
  logic [7:0] rsp_shift;

  // sample on the clk edge that raises sCLK for data bits 7..0 (bit_cnt 8..1 before the decrement)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_shift <= '0;
      rsp_rdata <= '0;
    end else if (state == SHIFT_LO && div_zero) begin
      if (bit_cnt != 4'd0 && bit_cnt <= 4'd8)
        rsp_shift <= {rsp_shift[6:0], CIPO};
      if (bit_cnt == 4'd0)
        rsp_rdata <= rsp_shift;
    end
  end
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: random frames compared cycle by cycle against a timing model.
// Exercises the SPI_CTRL_CIPO_EN read-back path when that macro is defined.
module tb_spi_controller;

  localparam int H     = 4;
  localparam int FRAME = 1 + 35 * H;
  localparam int MAXC  = 400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       cmd_ready, sCLK, nCS, COPI, busy, done;
`ifdef SPI_CTRL_CIPO_EN
  logic       CIPO = 1'b0;
  logic [7:0] rsp_rdata;
  logic [7:0] cipo_word = '0;
  logic [7:0] obs_rsp [0:MAXC-1];
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // observed {nCS, sCLK, COPI, done, cmd_ready, busy} per cycle after the accept edge
  logic [5:0] obs_vec [0:MAXC-1];

  spi_controller #(.HALF_PERIOD(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .sCLK      (sCLK),
    .nCS       (nCS),
    .COPI      (COPI),
    .busy      (busy),
`ifdef SPI_CTRL_CIPO_EN
    .CIPO      (CIPO),
    .rsp_rdata (rsp_rdata),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected pins t cycles after the accept edge, from the frame timing rules
  function automatic logic [5:0] model(input int t, input logic [15:0] f);
    logic ncs_e, sclk_e, copi_e, done_e, ready_e;
    int   idx;
    ncs_e  = !(t >= 1 && t <= 33 * H);
    sclk_e = (t >= 1 + H && t <= 33 * H) && (((t - 1 - H) / H) % 2 == 0);
    idx    = (t - 1) / (2 * H);
    if (idx > 15) idx = 15;
    copi_e  = (t >= 1 && t <= 33 * H) ? f[15 - idx] : 1'b0;
    done_e  = (t == 1 + 33 * H);
    ready_e = (t <= 0) || (t >= 1 + 35 * H);
    return {ncs_e, sclk_e, copi_e, done_e, ready_e, !ready_e};
  endfunction

  task automatic start_cmd(input logic [15:0] f);
    int waited = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL start_timeout: cmd_ready=%b, required 1", cmd_ready);
    end
    obs_vec[0] = {nCS, sCLK, COPI, done, cmd_ready, busy};
    cmd_valid = 1'b1;
    {cmd_rw, cmd_addr, cmd_wdata} = f;
`ifdef SPI_CTRL_CIPO_EN
    CIPO = 1'($urandom);
`endif
  endtask

  // mode 0: drop valid after accept; 1: hold valid, switch to next_cmd; 2: scramble inputs while busy
  task automatic capture(input int ncyc, input int mode, input logic [15:0] next_cmd);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      obs_vec[n] = {nCS, sCLK, COPI, done, cmd_ready, busy};
`ifdef SPI_CTRL_CIPO_EN
      obs_rsp[n] = rsp_rdata;
      begin
        int t, b;
        t = n + 1;
        b = 15 - (t - 1) / (2 * H);
        if (t >= 1 && t <= 32 * H && b <= 7) CIPO = cipo_word[b];
        else CIPO = 1'($urandom);
      end
`endif
      case (mode)
        0: cmd_valid = 1'b0;
        1: begin
          if (n == 1) {cmd_rw, cmd_addr, cmd_wdata} = next_cmd;
          if (n == FRAME + 1) cmd_valid = 1'b0;
        end
        default: begin
          if (n < 35 * H) begin
            cmd_valid = 1'($urandom_range(0, 1));
            {cmd_rw, cmd_addr, cmd_wdata} = 16'($urandom);
          end else begin
            cmd_valid = 1'b0;
          end
        end
      endcase
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({nCS, sCLK, COPI, done, cmd_ready, busy} !== 6'b100010) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: got %b, required 100010",
               {nCS, sCLK, COPI, done, cmd_ready, busy});
    end
`ifdef SPI_CTRL_CIPO_EN
    tests_run++;
    if (rsp_rdata !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_rsp: got %h, required 00", rsp_rdata);
    end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1'b1 || nCS !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_reset: cmd_ready=%b nCS=%b, required 1 1", cmd_ready, nCS);
    end
  endtask

  task automatic test_single_frames();
    logic [15:0] f;
    logic [15:0] word;
    int rises, first_rise, bad, first_bad, done_cnt;
    for (int i = 0; i < 5; i++) begin
      f = (i == 0) ? 16'h8480 : 16'($urandom);
      start_cmd(f);
      capture(FRAME, 0, 16'h0);

      bad = 0;
      first_bad = 0;
      for (int n = 1; n <= FRAME; n++) begin
        if (obs_vec[n] !== model(n, f)) begin
          if (bad == 0) first_bad = n;
          bad++;
        end
      end
      tests_run++;
      if (bad != 0) begin
        tests_failed++;
        $display("[TB] FAIL frame_waveform f=%h: cycle %0d got %b, required %b (%0d bad cycles)",
                 f, first_bad, obs_vec[first_bad], model(first_bad, f), bad);
      end

      rises = 0;
      first_rise = -1;
      word = '0;
      done_cnt = 0;
      for (int n = 1; n <= FRAME; n++) begin
        if (obs_vec[n][4] && !obs_vec[n-1][4]) begin
          if (first_rise < 0) first_rise = n;
          if (rises < 16) word[15 - rises] = obs_vec[n][3];
          rises++;
        end
        if (obs_vec[n][2]) done_cnt++;
      end
      tests_run++;
      if (rises != 16 || word !== f) begin
        tests_failed++;
        $display("[TB] FAIL copi_at_rises: got %0d rises word %h, required 16 rises word %h", rises, word, f);
      end
      tests_run++;
      if (first_rise != 1 + H || obs_vec[1][5] !== 1'b0 || obs_vec[0][5] !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL frame_start: first rise %0d nCS0=%b nCS1=%b, required %0d 1 0",
                 first_rise, obs_vec[0][5], obs_vec[1][5], 1 + H);
      end
      tests_run++;
      if (done_cnt != 1 || obs_vec[1 + 33 * H][2] !== 1'b1 || obs_vec[1 + 33 * H][5] !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL done_pulse: count %0d done@%0d=%b, required 1 pulse at nCS rise",
                 done_cnt, 1 + 33 * H, obs_vec[1 + 33 * H][2]);
      end
      tests_run++;
      if (obs_vec[FRAME][1] !== 1'b1 || obs_vec[FRAME - 1][1] !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL ready_return: ready@%0d=%b ready@%0d=%b, required 0 1",
                 FRAME - 1, obs_vec[FRAME - 1][1], FRAME, obs_vec[FRAME][1]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] f;
    int bad, first_bad;
    f = 16'($urandom);
    start_cmd(f);
    capture(FRAME, 2, 16'h0);
    bad = 0;
    first_bad = 0;
    for (int n = 1; n <= FRAME; n++) begin
      if (obs_vec[n] !== model(n, f)) begin
        if (bad == 0) first_bad = n;
        bad++;
      end
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL busy_ignore f=%h: cycle %0d got %b, required %b",
               f, first_bad, obs_vec[first_bad], model(first_bad, f));
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (nCS !== 1'b1 || cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL no_extra_accept: nCS=%b cmd_ready=%b, required 1 1", nCS, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] f1, f2, fx;
    int bad, first_bad, t, high_cnt;
    f1 = {1'b1, 7'h00, 8'hFF};
    f2 = {1'b1, 7'h02, 8'h0F};
    start_cmd(f1);
    capture(2 * FRAME, 1, f2);
    bad = 0;
    first_bad = 0;
    for (int n = 1; n <= 2 * FRAME; n++) begin
      t  = (n <= FRAME) ? n : n - FRAME;
      fx = (n <= FRAME) ? f1 : f2;
      if (obs_vec[n] !== model(t, fx)) begin
        if (bad == 0) first_bad = n;
        bad++;
      end
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back_waveform: cycle %0d got %b (%0d bad cycles)",
               first_bad, obs_vec[first_bad], bad);
    end
    high_cnt = 0;
    for (int n = 1 + 33 * H; n <= FRAME + 1; n++)
      if (obs_vec[n][5]) high_cnt++;
    tests_run++;
    if (high_cnt != 2 * H + 1 || obs_vec[FRAME + 1][5] !== 1'b0 || obs_vec[FRAME - 1][1] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL second_accept: nCS high %0d cycles, nCS@%0d=%b, required %0d and 0",
               high_cnt, FRAME + 1, obs_vec[FRAME + 1][5], 2 * H + 1);
    end
  endtask

`ifdef SPI_CTRL_CIPO_EN
  task automatic test_cipo_readback();
    for (int i = 0; i < 2; i++) begin
      cipo_word = (i == 0) ? 8'hA5 : 8'($urandom);
      start_cmd(16'($urandom));
      capture(FRAME, 0, 16'h0);
      tests_run++;
      if (obs_rsp[1 + 33 * H] !== cipo_word || obs_rsp[FRAME] !== cipo_word) begin
        tests_failed++;
        $display("[TB] FAIL cipo_readback: got %h at done, %h later, required %h",
                 obs_rsp[1 + 33 * H], obs_rsp[FRAME], cipo_word);
      end
    end
  endtask
`endif

  task automatic test_reset_midframe();
    logic [15:0] f;
    int t_rst, bad;
    f = 16'($urandom);
    t_rst = 2 + H + 2 * H * 5;
    start_cmd(f);
    for (int n = 1; n <= t_rst; n++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    tests_run++;
    if ({nCS, sCLK} !== {model(t_rst, f)[5], model(t_rst, f)[4]}) begin
      tests_failed++;
      $display("[TB] FAIL in_bit10: nCS=%b sCLK=%b, required 0 1", nCS, sCLK);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({nCS, sCLK, COPI, done, cmd_ready, busy} !== 6'b100010) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got %b, required 100010",
               {nCS, sCLK, COPI, done, cmd_ready, busy});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 2 * FRAME; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || nCS !== 1'b1 || cmd_ready !== 1'b1) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL after_reset_quiet: %0d cycles with done/nCS/cmd_ready off idle, required 0", bad);
    end
`ifdef SPI_CTRL_CIPO_EN
    tests_run++;
    if (rsp_rdata !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL rsp_after_reset: got %h, required 00", rsp_rdata);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_frames();
    test_busy_ignore();
    test_back_to_back();
`ifdef SPI_CTRL_CIPO_EN
    test_cipo_readback();
`endif
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
